// File: rtl/uart_brg_frac.sv
// UART baud-rate generator with integer+fractional divider.
// Emits an oversample tick (rx_tick) and a bit tick (tx_tick).
module uart_brg_frac #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4,
  parameter int unsigned BAUD0      = 9600,
  parameter int unsigned BAUD1      = 19200,
  parameter int unsigned BAUD2      = 57600,
  parameter int unsigned BAUD3      = 115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sw_mode,
  input  logic [1:0]        baud_sel,
  input  logic [DIV_W-1:0]  sw_div_int,
  input  logic [FRAC_W-1:0] sw_div_frac,
  input  logic              cfg_load,
  input  logic              restart,
  output logic              rx_tick,
  output logic              tx_tick,
  output logic              cfg_err
);

  localparam int unsigned TW = DIV_W + FRAC_W;
  localparam int unsigned OW =
    (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  function automatic logic [TW-1:0] tdiv(
    input longint unsigned baud
  );
    longint unsigned num;
    longint unsigned den;
    num = longint'(CLK_FREQ) << FRAC_W;
    den = baud * longint'(OVERSAMPLE);
    return TW'((num + den / 2) / den);
  endfunction

  localparam logic [TW-1:0] TDIV0 = tdiv(longint'(BAUD0));
  localparam logic [TW-1:0] TDIV1 = tdiv(longint'(BAUD1));
  localparam logic [TW-1:0] TDIV2 = tdiv(longint'(BAUD2));
  localparam logic [TW-1:0] TDIV3 = tdiv(longint'(BAUD3));

  localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  pend_int;
  logic [FRAC_W-1:0] pend_frac;
  logic              pend_valid;
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [OW-1:0]     os_cnt;

  logic [TW-1:0]     tbl_div;
  logic [DIV_W-1:0]  sel_int;
  logic [FRAC_W-1:0] sel_frac;
  logic              sel_bad;
  logic              pend_bad;
  logic [DIV_W:0]    last;
  logic [FRAC_W:0]   sum;
  logic              run;
  logic              wrap;
  logic              apply;
  logic              os_wrap;
  logic [OW-1:0]     os_next;

  always_comb begin
    tbl_div = TDIV0;
    unique case (baud_sel)
      2'd0: tbl_div = TDIV0;
      2'd1: tbl_div = TDIV1;
      2'd2: tbl_div = TDIV2;
      2'd3: tbl_div = TDIV3;
    endcase
  end

  always_comb begin
    sel_int  = tbl_div[TW-1:FRAC_W];
    sel_frac = tbl_div[FRAC_W-1:0];
    if (sw_mode) begin
      sel_int  = sw_div_int;
      sel_frac = sw_div_frac;
    end
  end

  // Period is act_int + carry; >= tolerates a shrink applied while frozen
  always_comb begin
    sel_bad  = sel_int < MIN_DIV;
    pend_bad = pend_int < MIN_DIV;
    last     = {1'b0, act_int}
             + {{DIV_W{1'b0}}, carry}
             - (DIV_W + 1)'(1);
    sum      = {1'b0, acc} + {1'b0, act_frac};
    run      = en && !cfg_err;
    wrap     = run && ({1'b0, cnt} >= last);
    apply    = pend_valid && (wrap || !en || cfg_err);
    os_wrap  = os_cnt == OS_LAST;
    os_next  = os_wrap ? '0 : os_cnt + OW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_int    <= TDIV0[TW-1:FRAC_W];
      act_frac   <= TDIV0[FRAC_W-1:0];
      pend_int   <= '0;
      pend_frac  <= '0;
      pend_valid <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      os_cnt     <= '0;
      rx_tick    <= 1'b0;
      tx_tick    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
      if (restart) begin
        cnt    <= '0;
        acc    <= '0;
        carry  <= 1'b0;
        os_cnt <= '0;
        if (cfg_load) begin
          act_int    <= sel_int;
          act_frac   <= sel_frac;
          cfg_err    <= sel_bad;
          pend_valid <= 1'b0;
        end
      end else if (apply) begin
        act_int    <= pend_int;
        act_frac   <= pend_frac;
        cfg_err    <= pend_bad;
        pend_valid <= 1'b0;
        acc        <= '0;
        carry      <= 1'b0;
        if (wrap) begin
          rx_tick <= 1'b1;
          tx_tick <= os_wrap;
        end
        if (wrap || pend_bad)
          cnt <= '0;
        if (pend_bad)
          os_cnt <= '0;
        else if (wrap)
          os_cnt <= os_next;
      end else if (wrap) begin
        rx_tick      <= 1'b1;
        tx_tick      <= os_wrap;
        cnt          <= '0;
        {carry, acc} <= sum;
        os_cnt       <= os_next;
      end else if (run) begin
        cnt <= cnt + DIV_W'(1);
      end
      // A fresh load overrides anything just consumed
      if (cfg_load && !restart) begin
        pend_int   <= sel_int;
        pend_frac  <= sel_frac;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_brg_frac.sv
// Directed bench for uart_brg_frac.
// Tick intervals are measured in clocks against hand values.
module tb_uart_brg_frac;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sw_mode;
  logic [1:0]  baud_sel;
  logic [15:0] sw_div_int;
  logic [3:0]  sw_div_frac;
  logic        cfg_load;
  logic        restart;
  logic        rx_tick;
  logic        tx_tick;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;
  int txbad  = 0;
  int c;
  int t;
  int miss;

  always #5 clk = ~clk;

  uart_brg_frac dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sw_mode     (sw_mode),
    .baud_sel    (baud_sel),
    .sw_div_int  (sw_div_int),
    .sw_div_frac (sw_div_frac),
    .cfg_load    (cfg_load),
    .restart     (restart),
    .rx_tick     (rx_tick),
    .tx_tick     (tx_tick),
    .cfg_err     (cfg_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic count_ticks(input int n, output int cyc, output int ntx);
    int nrx;
    nrx = 0;
    ntx = 0;
    cyc = 0;
    while (nrx < n && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (rx_tick) nrx++;
      if (tx_tick) ntx++;
      if (tx_tick && !rx_tick) txbad++;
    end
    if (nrx < n) chk("timeout", nrx, n);
  endtask

  task automatic pulse(input logic ld, input logic rs);
    cfg_load = ld;
    restart  = rs;
    @(negedge clk);
    cfg_load = 1'b0;
    restart  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sw_mode = 1'b0; baud_sel = 2'd0;
    sw_div_int = '0; sw_div_frac = '0;
    cfg_load = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx", int'(rx_tick), 0);
    chk("rst_tx", int'(tx_tick), 0);
    chk("rst_err", int'(cfg_err), 0);

    // BAUD0: 10417/16 -> 651 + 1/16
    rst = 1'b0;
    count_ticks(1, c, t);
    chk("t0_first", c, 651);
    count_ticks(31, c, t);
    chk("t0_31per", c, 20182);
    chk("t0_tx", t, 2);

    // BAUD3: 868/16 -> 54 + 4/16
    baud_sel = 2'd3;
    pulse(1'b1, 1'b1);
    count_ticks(1, c, t);
    chk("t3_first", c, 54);
    count_ticks(4, c, t);
    chk("t3_4per", c, 217);

    sw_mode = 1'b1; sw_div_int = 16'd4; sw_div_frac = 4'd0;
    pulse(1'b1, 1'b1);
    count_ticks(16, c, t);
    chk("sw4_16rx", c, 64);
    chk("sw4_tx", t, 1);
    chk("sw4_txlast", int'(tx_tick), 1);
    count_ticks(16, c, t);
    chk("sw4_16rx_b", c, 64);

    sw_div_frac = 4'd8;
    pulse(1'b1, 1'b1);
    count_ticks(1, c, t);
    chk("fr_p1", c, 4);
    count_ticks(1, c, t);
    chk("fr_p2", c, 4);
    count_ticks(1, c, t);
    chk("fr_p3", c, 5);
    count_ticks(29, c, t);
    chk("fr_29per", c, 130);

    sw_div_int = 16'd10; sw_div_frac = 4'd0;
    pulse(1'b1, 1'b1);
    count_ticks(1, c, t);
    chk("mid_p10", c, 10);
    repeat (3) @(negedge clk);
    sw_div_int = 16'd6;
    pulse(1'b1, 1'b0);
    count_ticks(1, c, t);
    chk("mid_rest", c, 6);
    sw_div_int = 16'd3;
    count_ticks(1, c, t);
    chk("mid_new6", c, 6);

    repeat (2) @(negedge clk);
    en = 1'b0;
    miss = 0;
    repeat (20) begin
      @(negedge clk);
      if (rx_tick || tx_tick) miss++;
    end
    en = 1'b1;
    count_ticks(1, c, t);
    chk("en_rest", c, 4);
    chk("en_quiet", miss, 0);

    repeat (3) @(negedge clk);
    pulse(1'b0, 1'b1);
    count_ticks(16, c, t);
    chk("rs_16rx", c, 96);
    chk("rs_tx", t, 1);

    sw_div_int = 16'd1;
    pulse(1'b1, 1'b0);
    count_ticks(1, c, t);
    chk("err1_last", c, 5);
    chk("err1_set", int'(cfg_err), 1);
    miss = 0;
    repeat (40) begin
      @(negedge clk);
      if (rx_tick || tx_tick) miss++;
    end
    chk("err1_quiet", miss, 0);
    sw_div_int = 16'd8;
    pulse(1'b1, 1'b0);
    count_ticks(1, c, t);
    chk("err_fix_first", c, 9);
    chk("err_clr", int'(cfg_err), 0);
    count_ticks(1, c, t);
    chk("err_fix_p8", c, 8);

    sw_div_int = 16'd0;
    pulse(1'b1, 1'b1);
    chk("err0_imm", int'(cfg_err), 1);
    sw_div_int = 16'd8;
    pulse(1'b1, 1'b1);
    chk("err0_clr", int'(cfg_err), 0);
    count_ticks(1, c, t);
    chk("p8_again", c, 8);

    // reset lands on the edge that would otherwise tick
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_rx", int'(rx_tick), 0);
    chk("mrst_tx", int'(tx_tick), 0);
    chk("mrst_err", int'(cfg_err), 0);
    rst = 1'b0;
    count_ticks(1, c, t);
    chk("mrst_baud0", c, 651);

    chk("tx_align", txbad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
